// File: rtl/uart_calc_pkg.sv
// Shared types and constants for the serial accumulator-calculator.
// Both the receiver and the top-level transmitter import this package.
package uart_calc_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_DONE
  } rxState_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } txState_e;

  localparam logic [7:0] DEF_ERR_CODE = 8'hEE;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;
  localparam int CNT_W      = 16;

  function automatic int calcClksPerBit(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

endpackage

// File: rtl/uart_calc_if.sv
// Board-side pins of the calculator: serial pair plus the LED bank.
// The host drives rx and watches tx/leds; the calculator does the reverse.
interface uart_calc_if;
  logic       rx;
  logic       tx;
  logic [7:0] leds;

  modport master (output rx, input tx, input leds);
  modport slave  (input rx, output tx, output leds);
endinterface

// File: rtl/uart_calc_rx.sv
// UART receiver: 2-FF synchronizer, mid-bit sampling FSM and even-parity/stop check.
// inFlag pulses for one cycle once a whole frame has been sampled.
module uart_calc_rx
  import uart_calc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       frame_ok_o,
  output logic       inFlag_o
);

  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TICK = CNT_W'(CLKS_PER_BIT - 1);

  rxState_e         state_q, state_d;
  logic             rxMeta_q, rxSync_q, rxPrev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shift_q;
  logic             parity_q, stop_q;
  logic             inFlag;
  logic             halfTick, fullTick;

  assign halfTick = (cnt_q == HALF_TICK);
  assign fullTick = (cnt_q == FULL_TICK);

  // Synchronizer resets to idle-high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_i;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:   if (rxPrev_q && !rxSync_q) state_d = RX_START;
      RX_START:  if (halfTick) state_d = rxSync_q ? RX_IDLE : RX_DATA;
      RX_DATA:   if (fullTick && bitIdx_q == 3'(DATA_BITS - 1)) state_d = RX_PARITY;
      RX_PARITY: if (fullTick) state_d = RX_STOP;
      RX_STOP:   if (fullTick) state_d = RX_DONE;
      RX_DONE:   state_d = RX_IDLE;
      default:   state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    inFlag = 1'b0;
    if (state_q == RX_DONE) inFlag = 1'b1;
  end

  // Bit counter restarts on every state change and after each data sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      if (state_d != state_q || (state_q == RX_DATA && fullTick)) cnt_q <= '0;
      else if (state_q != RX_IDLE)                                 cnt_q <= cnt_q + 1'b1;
      if (state_q == RX_START) bitIdx_q <= '0;
      if (state_q == RX_DATA && fullTick) begin
        shift_q  <= {rxSync_q, shift_q[7:1]};
        bitIdx_q <= bitIdx_q + 1'b1;
      end
      if (state_q == RX_PARITY && fullTick) parity_q <= rxSync_q;
      if (state_q == RX_STOP && fullTick)   stop_q   <= rxSync_q;
    end
  end

  assign data_o     = shift_q;
  assign frame_ok_o = ~(^shift_q ^ parity_q) & stop_q;
  assign inFlag_o   = inFlag;

endmodule

// File: rtl/uart_calc.sv
// Accumulator-calculator top: adds each good byte into acc, shows acc on the LEDs
// and echoes the new acc (or the error code) through a 1-deep pending slot to TX.
module uart_calc
  import uart_calc_pkg::*;
#(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         BAUD     = 19200,
  parameter logic [7:0] ERR_CODE = DEF_ERR_CODE
) (
  input logic        clk,
  input logic        rst,
  uart_calc_if.slave pins
);

  localparam int CLKS_PER_BIT = calcClksPerBit(CLK_FREQ, BAUD);
  localparam logic [CNT_W-1:0] FULL_TICK = CNT_W'(CLKS_PER_BIT - 1);

  logic [7:0]       rxData;
  logic             frameOk;
  logic             inFlag;
  logic [7:0]       acc_q, sum;
  logic [7:0]       pend_q;
  logic             pendValid_q;
  txState_e         txState_q, txState_d;
  logic [CNT_W-1:0] txCnt_q;
  logic [2:0]       txBitIdx_q;
  logic [7:0]       txShift_q;
  logic             txParity_q;
  logic             txTick;
  logic             txBit;

  uart_calc_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (pins.rx),
    .data_o     (rxData),
    .frame_ok_o (frameOk),
    .inFlag_o   (inFlag)
  );

  assign sum    = acc_q + rxData;
  assign txTick = (txCnt_q == FULL_TICK);

  // A new result always replaces the pending one; TX drains it from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      pend_q      <= '0;
      pendValid_q <= 1'b0;
    end else if (inFlag) begin
      if (frameOk) acc_q <= sum;
      pend_q      <= frameOk ? sum : ERR_CODE;
      pendValid_q <= 1'b1;
    end else if (txState_q == TX_IDLE && pendValid_q) begin
      pendValid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) txState_q <= TX_IDLE;
    else     txState_q <= txState_d;
  end

  always_comb begin
    txState_d = txState_q;
    case (txState_q)
      TX_IDLE:   if (pendValid_q) txState_d = TX_START;
      TX_START:  if (txTick) txState_d = TX_DATA;
      TX_DATA:   if (txTick && txBitIdx_q == 3'(DATA_BITS - 1)) txState_d = TX_PARITY;
      TX_PARITY: if (txTick) txState_d = TX_STOP;
      TX_STOP:   if (txTick) txState_d = TX_IDLE;
      default:   txState_d = TX_IDLE;
    endcase
  end

  always_comb begin
    txBit = 1'b1;
    case (txState_q)
      TX_START:  txBit = 1'b0;
      TX_DATA:   txBit = txShift_q[0];
      TX_PARITY: txBit = txParity_q;
      default:   txBit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txCnt_q    <= '0;
      txBitIdx_q <= '0;
      txShift_q  <= '0;
      txParity_q <= 1'b0;
    end else begin
      if (txState_d != txState_q || (txState_q == TX_DATA && txTick)) txCnt_q <= '0;
      else if (txState_q != TX_IDLE)                                   txCnt_q <= txCnt_q + 1'b1;
      if (txState_q == TX_IDLE && pendValid_q) begin
        txShift_q  <= pend_q;
        txParity_q <= ^pend_q;
        txBitIdx_q <= '0;
      end else if (txState_q == TX_DATA && txTick) begin
        txShift_q  <= {1'b0, txShift_q[7:1]};
        txBitIdx_q <= txBitIdx_q + 1'b1;
      end
    end
  end

  assign pins.tx   = txBit;
  assign pins.leds = acc_q;

endmodule

// File: tb/tb_uart_calc.sv
// Directed bench for uart_calc: table of frames with hand-computed LED/TX results,
// plus idle, back-to-back, glitch and mid-frame reset sequences.
module tb_uart_calc;
  import uart_calc_pkg::*;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] expLeds;
    logic [7:0] expTx;
    logic       expPar;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   flagCount;
  int   flagCyc;

  uart_calc_if bus();

  uart_calc #(.CLK_FREQ(160), .BAUD(10), .ERR_CODE(8'hEE)) dut (
    .clk  (clk),
    .rst  (rst),
    .pins (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut.inFlag) begin
      flagCount <= flagCount + 1;
      flagCyc   <= cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s, input int nBits);
    logic [FRAME_BITS-1:0] frame;
    frame = {s, p, d, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      bus.rx = frame[i];
      repeat (CPB) @(posedge clk);
    end
    bus.rx = 1'b1;
    if (!s && nBits == FRAME_BITS) repeat (CPB) @(posedge clk);
  endtask

  task automatic captureTx(output logic [7:0] d, output logic p, output logic s,
                           output logic st, output logic timedOut, output int startCyc);
    int waitCnt;
    waitCnt  = 0;
    timedOut = 1'b0;
    d = '0; p = 1'b0; s = 1'b0; st = 1'b1; startCyc = 0;
    @(negedge clk);
    while (bus.tx !== 1'b0 && waitCnt < 14 * CPB) begin
      @(negedge clk);
      waitCnt++;
    end
    if (bus.tx !== 1'b0) begin
      timedOut = 1'b1;
      return;
    end
    startCyc = cyc;
    repeat (CPB / 2) @(negedge clk);
    st = bus.tx;
    for (int i = 0; i < DATA_BITS; i++) begin
      repeat (CPB) @(negedge clk);
      d[i] = bus.tx;
    end
    repeat (CPB) @(negedge clk);
    p = bus.tx;
    repeat (CPB) @(negedge clk);
    s = bus.tx;
  endtask

  task automatic watchIdle(input int cycles, output int lowCount);
    lowCount = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) lowCount++;
    end
  endtask

  task automatic runVector(input vec_t v, input string tag, input logic checkLat);
    logic [7:0] d;
    logic       p, s, st, to;
    int         sc, flagsBefore;
    flagsBefore = flagCount;
    fork
      applyStimulus(v.data, v.par, v.stop, FRAME_BITS);
      captureTx(d, p, s, st, to, sc);
    join
    repeat (2) @(negedge clk);
    checkOutput({tag, " timeout"}, 32'(to), 32'd0);
    checkOutput({tag, " inFlag pulses"}, 32'(flagCount - flagsBefore), 32'd1);
    checkOutput({tag, " leds"}, 32'(bus.leds), 32'(v.expLeds));
    checkOutput({tag, " tx start"}, 32'(st), 32'd0);
    checkOutput({tag, " tx data"}, 32'(d), 32'(v.expTx));
    checkOutput({tag, " tx parity"}, 32'(p), 32'(v.expPar));
    checkOutput({tag, " tx stop"}, 32'(s), 32'd1);
    if (checkLat) checkOutput({tag, " tx latency ok"}, 32'((sc - flagCyc) >= 1 && (sc - flagCyc) <= 2), 32'd1);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    logic [7:0] d1, d2;
    logic       p1, p2, s1, s2, st1, st2, to1, to2;
    int         sc1, sc2, lows, flagsBefore;

    checks = 0; errors = 0; cyc = 0; flagCount = 0; flagCyc = 0;

    vecs[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 8'h55, 1'b0};
    vecs[1] = '{8'h55, 1'b1, 1'b1, 8'h55, 8'hEE, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h55, 8'hEE, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 8'hD5, 8'hD5, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 8'hD5, 8'hEE, 1'b0};
    vecs[5] = '{8'h2B, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};

    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset tx", 32'(bus.tx), 32'd1);
    checkOutput("reset leds", 32'(bus.leds), 32'd0);
    rst = 1'b0;
    watchIdle(4 * CPB, lows);
    checkOutput("idle tx low samples", 32'(lows), 32'd0);
    checkOutput("idle inFlag pulses", 32'(flagCount), 32'd0);
    checkOutput("idle leds", 32'(bus.leds), 32'd0);

    for (int i = 0; i < 6; i++) runVector(vecs[i], $sformatf("vec%0d", i), 1'b1);

    flagsBefore = flagCount;
    fork
      begin
        applyStimulus(8'h10, 1'b1, 1'b1, FRAME_BITS);
        applyStimulus(8'h03, 1'b0, 1'b1, FRAME_BITS);
      end
      begin
        captureTx(d1, p1, s1, st1, to1, sc1);
        captureTx(d2, p2, s2, st2, to2, sc2);
      end
    join
    repeat (2) @(negedge clk);
    checkOutput("b2b timeouts", 32'({to1, to2}), 32'd0);
    checkOutput("b2b inFlag pulses", 32'(flagCount - flagsBefore), 32'd2);
    checkOutput("b2b first data", 32'(d1), 32'h10);
    checkOutput("b2b first parity", 32'(p1), 32'd1);
    checkOutput("b2b second data", 32'(d2), 32'h13);
    checkOutput("b2b second parity", 32'(p2), 32'd1);
    checkOutput("b2b stops", 32'({s1, s2}), 32'b11);
    checkOutput("b2b leds", 32'(bus.leds), 32'h13);

    flagsBefore = flagCount;
    bus.rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    bus.rx = 1'b1;
    watchIdle(12 * CPB, lows);
    checkOutput("glitch inFlag pulses", 32'(flagCount - flagsBefore), 32'd0);
    checkOutput("glitch tx low samples", 32'(lows), 32'd0);
    checkOutput("glitch leds", 32'(bus.leds), 32'h13);

    applyStimulus(8'h07, 1'b1, 1'b1, FRAME_BITS);
    applyStimulus(8'h00, 1'b0, 1'b1, 4);
    @(negedge clk);
    checkOutput("pre-reset leds", 32'(bus.leds), 32'h1A);
    flagsBefore = flagCount;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-frame reset tx", 32'(bus.tx), 32'd1);
    checkOutput("mid-frame reset leds", 32'(bus.leds), 32'd0);
    rst = 1'b0;
    watchIdle(15 * CPB, lows);
    checkOutput("post-reset tx low samples", 32'(lows), 32'd0);
    checkOutput("post-reset inFlag pulses", 32'(flagCount - flagsBefore), 32'd0);

    v = '{8'h42, 1'b0, 1'b1, 8'h42, 8'h42, 1'b0};
    runVector(v, "after reset", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_calc.md
# uart_calc

Serial accumulator-calculator: receives 8-bit operands over an 11-bit parity UART frame, adds each parity-correct operand into an 8-bit accumulator, shows the accumulator on `leds`, and transmits the result (or an error code) back on `tx`. Sits between the board UART pins and the LED bank. It is driven by a host-side UART transmitter using the same frame format.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 19200, serial bit rate; `CLKS_PER_BIT = CLK_FREQ/BAUD` (2604 at defaults, integer truncation).
- `ERR_CODE`, 8'hEE, byte transmitted on a parity or stop-bit error.
- `clk`  in  1  system clock; one clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `tx`  out  1  serial output, idle high.
- `leds`  out  8  current accumulator value.

## Operation
- Frame on both `rx` and `tx`: start (0), 8 data bits LSB first, parity bit, stop (1); 11 bits total.
- The received parity is checked as even parity: the XOR of the 8 data bits and the parity bit must be 0. The transmitted parity is always even.
- `rx` passes through a 2-FF synchronizer before any use.
- RX FSM:
  - IDLE -> START when a falling edge is detected on synchronized `rx`.
  - START: at `CLKS_PER_BIT/2`, `rx` is re-sampled. If it is low, go to DATA; if high, the edge was a glitch and the FSM returns to IDLE.
  - DATA: 8 samples at `CLKS_PER_BIT` spacing, shifted in LSB first.
  - PARITY: one sample.
  - STOP: one sample, then DONE for one cycle, then IDLE.
- Internal signal `inFlag` pulses high for exactly one cycle in DONE. It must keep this exact name because benches probe it hierarchically.
- On `inFlag`:
  - If parity is OK and stop = 1: `acc <= acc + data` (mod 256), and the TX payload is the new `acc`.
  - Otherwise: `acc` is unchanged and the TX payload is `ERR_CODE`.
- `leds` = `acc` at all times.
- TX FSM: IDLE -> START -> DATA (8 bits) -> PARITY -> STOP -> IDLE, with each bit held `CLKS_PER_BIT` cycles.
- A result is loaded on the cycle after `inFlag`. If TX is still busy, the result is held in a 1-deep pending register and sent as soon as TX reaches IDLE. A further result arriving while pending is full overwrites the pending one, so only the newest is kept.

## Timing
- Reset values: `tx`=1, `leds`=0, `acc`=0, `inFlag`=0, both FSMs in IDLE, pending register empty.
- Reset asserted mid-frame aborts RX and TX. `tx` is 1 on the cycle after `rst` is sampled high.
- `inFlag` occurs about 10.5 bit times after the start edge, plus 2 synchronizer cycles. At defaults this is about 547 µs.
- `leds` updates on the cycle after `inFlag`.
- The `tx` start bit begins within 2 cycles of `inFlag` when TX is idle.
- The full TX frame lasts exactly `11*CLKS_PER_BIT` cycles.
- Back-to-back frames are supported. RX returns to IDLE at mid-stop-bit, so a new start edge is accepted immediately after.

## Structure
- Shared package `uart_calc_pkg` holds:
  - RX and TX state enums;
  - `ERR_CODE`;
  - a `CLKS_PER_BIT` function;
  - the frame bit-count constants (8 data, 11 total).
- One natural sub-module, `uart_calc_rx`: synchronizer, RX FSM, and parity/stop check. Its outputs are `data`, `frame_ok` and `inFlag`.
- The TX FSM, accumulator and pending register stay in the top level.

## Test plan
- Reset, hold `rx`=1: `leds`=0x00 and `tx`=1 throughout; `inFlag` never pulses.
- Send 0x55 with even parity (parity bit 0): one `inFlag` pulse, `leds`=0x55, and `tx` emits a frame of 0x55 with parity bit 0.
- Then send 0x55 with odd parity (parity bit 1): parity error, `leds` stays 0x55, and `tx` emits 0xEE with parity bit 0.
- Then send 0x00 with odd parity (parity bit 1): error, `leds` stays 0x55, and `tx` emits 0xEE.
- Then send 0x80 with even parity (parity bit 1): `leds`=0xD5 and `tx` emits 0xD5 with parity bit 1.
- Send a frame with stop bit 0, a 1/4-bit start glitch, and a reset mid-frame: error code on a bad stop bit; no `inFlag` on the glitch; after reset, `tx`=1 and `leds`=0.
